// File: rtl/density_writer.sv
// Write-side owner of the fluid-density BRAM: clears every cell to INIT_DENSITY, then streams cells in raster order.
// Optional macro BARRIER_PAINT_EN adds single-cell barrier paint/erase writes that take priority over the stream.
module density_writer #(
    parameter int         BRAM_DEPTH   = 31570,
    parameter int         GRID_W       = 205,
    parameter int         GRID_H       = 154,
    parameter logic [7:0] INIT_DENSITY = 8'd28
) (
    input  logic                          pixel_clk_in,
    input  logic                          rst_in,
    input  logic                          init_in,
    input  logic [8:0][7:0]               cell_data_in,
    input  logic                          cell_valid_in,
    output logic                          cell_ready_out,
    input  logic                          paint_valid_in,
    input  logic [7:0]                    paint_x_in,
    input  logic [7:0]                    paint_y_in,
    input  logic                          paint_erase_in,
    output logic                          paint_ack_out,
    output logic [$clog2(BRAM_DEPTH)-1:0] bram_addr_out,
    output logic [8:0][7:0]               bram_data_out,
    output logic                          bram_we_out,
    output logic                          busy_out,
    output logic                          frame_done_out
);

    localparam int                AW           = $clog2(BRAM_DEPTH);
    localparam logic [AW-1:0]     LAST         = AW'(BRAM_DEPTH - 1);
    localparam logic [8:0][7:0]   INIT_CELL    = {9{INIT_DENSITY}};
    localparam logic [8:0][7:0]   BARRIER_CELL = {9{8'hFF}};

    if (BRAM_DEPTH != GRID_W * GRID_H) begin : g_bad_depth
        $error("BRAM_DEPTH must equal GRID_W*GRID_H");
    end
    if (INIT_DENSITY == 8'hFF) begin : g_bad_init
        $error("INIT_DENSITY must differ from the barrier value");
    end

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   clr_ptr, clr_ptr_nx;
    logic [AW-1:0]   str_ptr, str_ptr_nx;

    logic            wr_en_p0;
    logic [AW-1:0]   wr_addr_p0;
    logic [8:0][7:0] wr_data_p0;
    logic            frame_end_p0;
    logic            ack_p0;
    logic            busy;
    logic            ready;

    logic            paint_take;
    logic [AW-1:0]   paint_addr;
    logic [8:0][7:0] paint_cell;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef BARRIER_PAINT_EN
    logic paint_in_range;

    assign paint_in_range = (32'(paint_x_in) < GRID_W) && (32'(paint_y_in) < GRID_H);
    assign paint_take     = paint_valid_in && paint_in_range && !init_in;
    // Full-width product first so a large y cannot alias before the final truncation.
    assign paint_addr     = AW'(32'(paint_x_in) + 32'(GRID_W) * 32'(paint_y_in));
    assign paint_cell     = paint_erase_in ? INIT_CELL : BARRIER_CELL;
`else
    logic unused_paint;

    assign unused_paint = ^{paint_valid_in, paint_x_in, paint_y_in, paint_erase_in};
    assign paint_take   = 1'b0;
    assign paint_addr   = '0;
    assign paint_cell   = INIT_CELL;
`endif

    always_comb begin
        state_nx     = state;
        clr_ptr_nx   = clr_ptr;
        str_ptr_nx   = str_ptr;
        wr_en_p0     = 1'b0;
        wr_addr_p0   = bram_addr_out;
        wr_data_p0   = bram_data_out;
        frame_end_p0 = 1'b0;
        ack_p0       = 1'b0;
        busy         = 1'b0;
        ready        = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (init_in) begin
                    clr_ptr_nx = '0;
                end else begin
                    wr_en_p0   = 1'b1;
                    wr_addr_p0 = clr_ptr;
                    wr_data_p0 = INIT_CELL;
                    clr_ptr_nx = wrap_inc(clr_ptr);
                    if (clr_ptr == LAST) state_nx = RUN;
                end
            end
            RUN: begin
                if (init_in) begin
                    state_nx   = CLEAR;
                    clr_ptr_nx = '0;
                    str_ptr_nx = '0;
                end else if (paint_take) begin
                    wr_en_p0   = 1'b1;
                    wr_addr_p0 = paint_addr;
                    wr_data_p0 = paint_cell;
                    ack_p0     = 1'b1;
                end else begin
                    ready = 1'b1;
                    if (cell_valid_in) begin
                        wr_en_p0     = 1'b1;
                        wr_addr_p0   = str_ptr;
                        wr_data_p0   = cell_data_in;
                        frame_end_p0 = (str_ptr == LAST);
                        str_ptr_nx   = wrap_inc(str_ptr);
                    end
                end
            end
        endcase
    end

    assign busy_out       = busy && !rst_in;
    assign cell_ready_out = ready && !rst_in;

    // p0 -> p1: write request registered onto the BRAM port
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state          <= CLEAR;
            clr_ptr        <= '0;
            str_ptr        <= '0;
            bram_we_out    <= 1'b0;
            bram_addr_out  <= '0;
            bram_data_out  <= '0;
            frame_done_out <= 1'b0;
            paint_ack_out  <= 1'b0;
        end else begin
            state          <= state_nx;
            clr_ptr        <= clr_ptr_nx;
            str_ptr        <= str_ptr_nx;
            bram_we_out    <= wr_en_p0;
            bram_addr_out  <= wr_addr_p0;
            bram_data_out  <= wr_data_p0;
            frame_done_out <= frame_end_p0;
            paint_ack_out  <= ack_p0;
        end
    end

endmodule

// File: tb/tb_density_writer.sv
// Bench for density_writer: full-size instance for clear/frame/paint, small instance for init and reset corners.
module tb_density_writer;

    localparam int DA = 31570;
    localparam int DB = 820;
    localparam logic [71:0] INIT9 = {9{8'd28}};
    localparam logic [71:0] FF9   = {9{8'hFF}};
`ifdef BARRIER_PAINT_EN
    localparam bit PAINT = 1'b1;
`else
    localparam bit PAINT = 1'b0;
`endif

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A (full grid)
    logic a_rst, a_init, a_valid, a_ready, a_pv, a_er, a_ack, a_we, a_busy, a_fd;
    logic [8:0][7:0] a_data, a_bdata;
    logic [7:0] a_px, a_py;
    logic [14:0] a_addr;
    // instance B (205x4 grid)
    logic b_rst, b_init, b_valid, b_ready, b_pv, b_er, b_ack, b_we, b_busy, b_fd;
    logic [8:0][7:0] b_data, b_bdata;
    logic [7:0] b_px, b_py;
    logic [9:0] b_addr;

    density_writer dut (
        .pixel_clk_in(clk), .rst_in(a_rst), .init_in(a_init),
        .cell_data_in(a_data), .cell_valid_in(a_valid), .cell_ready_out(a_ready),
        .paint_valid_in(a_pv), .paint_x_in(a_px), .paint_y_in(a_py), .paint_erase_in(a_er),
        .paint_ack_out(a_ack), .bram_addr_out(a_addr), .bram_data_out(a_bdata),
        .bram_we_out(a_we), .busy_out(a_busy), .frame_done_out(a_fd)
    );

    density_writer #(.BRAM_DEPTH(DB), .GRID_W(205), .GRID_H(4), .INIT_DENSITY(8'd28)) dut_s (
        .pixel_clk_in(clk), .rst_in(b_rst), .init_in(b_init),
        .cell_data_in(b_data), .cell_valid_in(b_valid), .cell_ready_out(b_ready),
        .paint_valid_in(b_pv), .paint_x_in(b_px), .paint_y_in(b_py), .paint_erase_in(b_er),
        .paint_ack_out(b_ack), .bram_addr_out(b_addr), .bram_data_out(b_bdata),
        .bram_we_out(b_we), .busy_out(b_busy), .frame_done_out(b_fd)
    );

    typedef struct {
        int          addr;
        logic [71:0] data;
        logic        fd;
        logic        ack;
        int          cyc;
    } exp_t;

    typedef struct {
        logic v; logic pv; int px; int py; logic er;
        logic rdy; int kind; int paddr; logic [71:0] pdata;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   a_sp = 0;
    int   b_sp = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [71:0] cell_of(input int a);
        logic [71:0] r;
        for (int j = 0; j < 9; j++) r[8*j +: 8] = 8'(a + 37 * j);
        return r;
    endfunction

    function automatic int qsz(input int id);
        return (id == 0) ? qa.size() : qb.size();
    endfunction

    function automatic exp_t popq(input int id);
        if (id == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    function automatic exp_t frontq(input int id);
        if (id == 0) return qa[0];
        return qb[0];
    endfunction

    task automatic push(input int id, input int addr, input logic [71:0] data, input logic fd, input logic ack);
        exp_t e;
        e.addr = addr; e.data = data; e.fd = fd; e.ack = ack; e.cyc = cyc + 1;
        if (id == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic mon(input int id, input logic we, input int addr, input logic [71:0] data,
                       input logic fd, input logic ack);
        exp_t  e;
        string p;
        p = (id == 0) ? "a" : "b";
        while (qsz(id) > 0 && frontq(id).cyc < cyc) begin
            e = popq(id);
            chk({p, "_missed_write_cycle"}, 72'(cyc), 72'(e.cyc));
        end
        if (we === 1'b1) begin
            if (qsz(id) == 0) begin
                chk({p, "_unexpected_write"}, 72'(1), 72'(0));
            end else begin
                e = popq(id);
                chk({p, "_addr"}, 72'(addr), 72'(e.addr));
                chk({p, "_data"}, data, e.data);
                chk({p, "_frame_done"}, 72'(fd), 72'(e.fd));
                chk({p, "_paint_ack"}, 72'(ack), 72'(e.ack));
                chk({p, "_write_cycle"}, 72'(cyc), 72'(e.cyc));
            end
        end else if (fd === 1'b1 || ack === 1'b1) begin
            chk({p, "_pulse_without_we"}, 72'({fd, ack}), 72'(0));
        end
    endtask

    always @(negedge clk) mon(0, a_we, int'(a_addr), a_bdata, a_fd, a_ack);
    always @(negedge clk) mon(1, b_we, int'(b_addr), b_bdata, b_fd, b_ack);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("a_busy_clear", 72'(a_busy), 72'(1));
            chk("a_ready_clear", 72'(a_ready), 72'(0));
            push(0, i, INIT9, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic clear_b(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("b_busy_clear", 72'(b_busy), 72'(1));
            chk("b_ready_clear", 72'(b_ready), 72'(0));
            push(1, i, INIT9, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic cell_a(input logic v);
        a_valid = v;
        a_data  = cell_of(a_sp);
        #1;
        chk("a_ready_run", 72'(a_ready), 72'(1));
        chk("a_busy_run", 72'(a_busy), 72'(0));
        if (v) begin
            push(0, a_sp, cell_of(a_sp), a_sp == DA - 1, 1'b0);
            a_sp = (a_sp == DA - 1) ? 0 : a_sp + 1;
        end
        tick();
        a_valid = 1'b0;
    endtask

    task automatic cell_b(input logic v);
        b_valid = v;
        b_data  = cell_of(b_sp);
        #1;
        chk("b_ready_run", 72'(b_ready), 72'(1));
        if (v) begin
            push(1, b_sp, cell_of(b_sp), b_sp == DB - 1, 1'b0);
            b_sp = (b_sp == DB - 1) ? 0 : b_sp + 1;
        end
        tick();
        b_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, input logic pv, input int px, input int py,
                                input logic er, input int paddr);
        vec_t m;
        logic take;
        take    = PAINT && pv && (px < 205) && (py < 154);
        m.v     = v; m.pv = pv; m.px = px; m.py = py; m.er = er;
        m.rdy   = !take;
        m.kind  = take ? 2 : (v ? 1 : 0);
        m.paddr = paddr;
        m.pdata = er ? INIT9 : FF9;
        return m;
    endfunction

    task automatic seq_a();
        vec_t tv[7];
        int   acc;
        int   sl;
        tv[0] = mk(1'b1, 1'b0, 0,   0,   1'b0, 0);
        tv[1] = mk(1'b1, 1'b1, 10,  3,   1'b0, 625);
        tv[2] = mk(1'b1, 1'b0, 0,   0,   1'b0, 0);
        tv[3] = mk(1'b1, 1'b1, 205, 0,   1'b0, 0);
        tv[4] = mk(1'b0, 1'b1, 0,   153, 1'b1, 31365);
        tv[5] = mk(1'b1, 1'b1, 0,   154, 1'b0, 0);
        tv[6] = mk(1'b0, 1'b0, 0,   0,   1'b0, 0);

        repeat (3) tick();
        chk("a_reset_we", 72'(a_we), 72'(0));
        chk("a_reset_busy", 72'(a_busy), 72'(0));
        chk("a_reset_ready", 72'(a_ready), 72'(0));
        chk("a_reset_addr", 72'(a_addr), 72'(0));
        chk("a_reset_data", a_bdata, 72'(0));
        chk("a_reset_frame_done", 72'(a_fd), 72'(0));
        chk("a_reset_ack", 72'(a_ack), 72'(0));
        a_rst = 1'b0;
        clear_a(DA);

        acc = 0;
        sl  = 0;
        while (acc < DA) begin
            cell_a((sl < 2000) ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (a_sp != acc % DA) acc = acc + 1;
            sl++;
        end
        cell_a(1'b1);

        for (int i = 0; i < 7; i++) begin
            a_valid = tv[i].v;
            a_data  = cell_of(a_sp);
            a_pv    = tv[i].pv;
            a_px    = 8'(tv[i].px);
            a_py    = 8'(tv[i].py);
            a_er    = tv[i].er;
            #1;
            chk($sformatf("a_vec%0d_ready", i), 72'(a_ready), 72'(tv[i].rdy));
            if (tv[i].kind == 1) begin
                push(0, a_sp, cell_of(a_sp), a_sp == DA - 1, 1'b0);
                a_sp = (a_sp == DA - 1) ? 0 : a_sp + 1;
            end else if (tv[i].kind == 2) begin
                push(0, tv[i].paddr, tv[i].pdata, 1'b0, 1'b1);
            end
            tick();
        end
        a_valid = 1'b0;
        a_pv    = 1'b0;
        repeat (3) tick();
    endtask

    task automatic seq_b();
        repeat (3) tick();
        chk("b_reset_we", 72'(b_we), 72'(0));
        chk("b_reset_busy", 72'(b_busy), 72'(0));
        b_rst = 1'b0;
        clear_b(DB);
        for (int i = 0; i < 300; i++) cell_b($urandom_range(0, 2) != 0);

        // init with a cell presented: that cell must not be taken
        b_init  = 1'b1;
        b_valid = 1'b1;
        b_data  = cell_of(b_sp);
        #1;
        chk("b_ready_on_init", 72'(b_ready), 72'(0));
        tick();
        b_init  = 1'b0;
        b_valid = 1'b0;
        b_sp    = 0;
        clear_b(DB);
        for (int i = 0; i < 40; i++) cell_b(1'b1);

        // reset together with init, paint and a pending cell
        b_rst   = 1'b1;
        b_init  = 1'b1;
        b_pv    = 1'b1;
        b_px    = 8'd10;
        b_py    = 8'd3;
        b_valid = 1'b1;
        #1;
        chk("b_ready_in_reset", 72'(b_ready), 72'(0));
        tick();
        b_rst   = 1'b0;
        b_init  = 1'b0;
        b_pv    = 1'b0;
        b_valid = 1'b0;
        #1;
        chk("b_we_after_reset", 72'(b_we), 72'(0));
        chk("b_ack_after_reset", 72'(b_ack), 72'(0));
        b_sp = 0;
        clear_b(100);

        // reset in the middle of a clear
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        clear_b(DB);
        for (int i = 0; i < 3; i++) cell_b(1'b1);
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst = 1'b1; a_init = 1'b0; a_valid = 1'b0; a_data = '0;
        a_pv = 1'b0; a_px = '0; a_py = '0; a_er = 1'b0;
        b_rst = 1'b1; b_init = 1'b0; b_valid = 1'b0; b_data = '0;
        b_pv = 1'b0; b_px = '0; b_py = '0; b_er = 1'b0;
        fork
            seq_a();
            seq_b();
        join
        chk("a_queue_drained", 72'(qa.size()), 72'(0));
        chk("b_queue_drained", 72'(qb.size()), 72'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
